loader_bus_bridge: RTL
======================

LOADER_BUS_BRIDGE -- requirements
Module: loader_bus_bridge

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0010_0000, meaning the lowest writable byte address.
REQ-002 The block SHALL have parameter SIZE_BYTES, default 65536, meaning the writable window length; it is a power of two.
REQ-003 The block SHALL have parameter RELEASE_DLY, default 16, meaning the number of cycles core reset stays high after the load ends; the range is 1..255.
REQ-004 The block SHALL have port clk_sys_i, input, 1 bit, the single system clock.
REQ-005 The block SHALL have port rst_sys_i, input, 1 bit, an asynchronous active-high reset.
REQ-006 The block SHALL have ports ld_req_i (input, 1), ld_en_i (input, 1, write enable), ld_addr_i (input, 32), ld_wdata_i (input, 32) and ld_be_i (input, 4), carrying the loader write request.
REQ-007 The block SHALL have port ld_rst_ni, input, 1 bit; the loader drives it low to hold the core in reset while loading.
REQ-008 The block SHALL have port ld_rvalid_o, output, 1 bit, a one-cycle completion pulse returned to the loader for each request.
REQ-009 The block SHALL have ports mem_req_o (output, 1), mem_we_o (output, 1), mem_addr_o (output, 32), mem_wdata_o (output, 32) and mem_be_o (output, 4), forming the memory request.
REQ-010 The block SHALL have ports mem_gnt_i (input, 1) and mem_rvalid_i (input, 1), the memory grant and response.
REQ-011 The block SHALL have port core_rst_o, output, 1 bit, the active-high Ibex core reset.
REQ-012 The block SHALL have port word_cnt_o, output, 16 bits, the count of writes accepted into the window; it saturates at 16'hFFFF.
REQ-013 The block SHALL have port checksum_o, output, 32 bits, the modulo-2^32 sum of byte-masked write data.
REQ-014 The block SHALL have port err_o, output, 1 bit, a sticky error flag.

Function
REQ-015 The FSM states SHALL be IDLE, LOAD, ISSUE, WAIT_RV, RELEASE and RUN.
REQ-016 From IDLE, ld_rst_ni=0 SHALL go to LOAD; ld_rst_ni=1 SHALL go to RELEASE.
REQ-017 In LOAD, ld_req_i=1 SHALL capture addr, wdata, be and en into holding registers in that cycle.
REQ-018 A captured request inside [BASE_ADDR, BASE_ADDR+SIZE_BYTES) SHALL go to ISSUE; otherwise it SHALL set err_o, drop the request and pulse ld_rvalid_o on the next cycle.
REQ-019 In ISSUE, mem_req_o SHALL be 1 with the held fields, stable until the cycle mem_gnt_i=1, then the FSM SHALL go to WAIT_RV.
REQ-020 In WAIT_RV, mem_rvalid_i=1 SHALL pulse ld_rvalid_o on the following cycle and return the FSM to LOAD.
REQ-021 Each granted write with en=1 SHALL increment word_cnt_o and add (wdata AND byte-mask(be)) to checksum_o in the grant cycle.
REQ-022 A granted request with en=0 SHALL be issued as a read (mem_we_o=0) and SHALL NOT change the counters.
REQ-023 A ld_req_i=1 seen in ISSUE or WAIT_RV is an overflow: it SHALL set err_o and be ignored, with no ld_rvalid_o for it.
REQ-024 ld_rst_ni rising in LOAD SHALL go to RELEASE; rising during ISSUE or WAIT_RV SHALL be remembered, and RELEASE entered after the outstanding response completes.
REQ-025 RELEASE SHALL hold core_rst_o=1 for exactly RELEASE_DLY cycles, then go to RUN.
REQ-026 In RUN, core_rst_o SHALL be 0 and loader requests SHALL be ignored without setting err_o.
REQ-027 ld_rst_ni=0 in RUN or RELEASE SHALL drive core_rst_o=1 in the same cycle (combinational), go to LOAD, and clear word_cnt_o, checksum_o and err_o.
REQ-028 core_rst_o SHALL be 1 in every state except RUN.
REQ-029 mem_req_o SHALL be 0 outside ISSUE.
REQ-030 ld_rvalid_o SHALL never pulse twice for one request.

Reset
REQ-031 rst_sys_i=1 SHALL asynchronously force state IDLE, core_rst_o=1, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0, ld_rvalid_o=0, word_cnt_o=0, checksum_o=0, err_o=0 and the pending-release flag to 0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no ld_rvalid_o pulse.

Structure
REQ-033 Package loader_pkg SHALL hold the state enum and a byte-mask expansion function shared with ram_config.
REQ-034 The block SHALL be a single module with no sub-modules.

Verification
REQ-035 The bench SHALL check that with ld_rst_ni=0, a write to 0x0010_0004, data 0xDEADBEEF, be 4'hF, gnt after 2 cycles produces mem_we_o=1, word_cnt_o=1, checksum_o=0xDEADBEEF and one ld_rvalid_o pulse.
REQ-036 The bench SHALL check that be=4'b0011 with data 0x12345678 adds 0x00005678 to checksum_o.
REQ-037 The bench SHALL check that a write to 0x0000_0000 produces no mem_req_o, err_o=1, and one ld_rvalid_o pulse.
REQ-038 The bench SHALL check that ld_rst_ni rising while in WAIT_RV keeps core_rst_o=1 until the response arrives plus 16 cycles, then 0.
REQ-039 The bench SHALL check that ld_rst_ni falling in RUN raises core_rst_o in the same cycle and clears word_cnt_o, checksum_o and err_o.
REQ-040 The bench SHALL check that rst_sys_i asserted while in ISSUE drops mem_req_o asynchronously, with no ld_rvalid_o pulse.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the loader-to-memory bridge: FSM state encoding
// and the byte-enable to bit-mask expansion also used by ram_config.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_RV,
        RELEASE,
        RUN
    } loader_state_e;

    // Expands a 4-bit byte enable into a 32-bit data mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/loader_bus_bridge.sv
// Bridges a program loader onto the instruction/data memory bus while the
// Ibex core is held in reset, tracks accepted writes and their checksum, and
// releases the core a fixed number of cycles after loading completes.
module loader_bus_bridge
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int unsigned SIZE_BYTES  = 65536,
    parameter int unsigned RELEASE_DLY = 16
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_i,
    input  logic        ld_req_i,
    input  logic        ld_en_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_wdata_i,
    input  logic [3:0]  ld_be_i,
    input  logic        ld_rst_ni,
    output logic        ld_rvalid_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        core_rst_o,
    output logic [15:0] word_cnt_o,
    output logic [31:0] checksum_o,
    output logic        err_o
);

    // Window bounds widened by one bit so BASE_ADDR+SIZE_BYTES cannot wrap.
    localparam logic [32:0] WIN_LO   = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI   = {1'b0, BASE_ADDR} + 33'(SIZE_BYTES);
    localparam logic [7:0]  REL_LAST = 8'(RELEASE_DLY - 1);

    loader_state_e state, state_nxt;
    logic          pend_release;
    logic [7:0]    rel_cnt;

    logic          in_window;
    logic          capture;
    logic          err_set;
    logic          rvalid_nxt;
    logic          account;
    logic          clear_stats;
    logic          pend_set;
    logic          pend_clr;
    logic          rel_start;

    assign in_window  = ({1'b0, ld_addr_i} >= WIN_LO) && ({1'b0, ld_addr_i} < WIN_HI);
    assign mem_req_o  = (state == ISSUE);
    assign core_rst_o = (state != RUN) || !ld_rst_ni;

    // Next-state decode plus the per-cycle datapath strobes.
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        err_set     = 1'b0;
        rvalid_nxt  = 1'b0;
        account     = 1'b0;
        clear_stats = 1'b0;
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        rel_start   = 1'b0;
        case (state)
            IDLE: begin
                if (!ld_rst_ni) begin
                    state_nxt = LOAD;
                end else begin
                    state_nxt = RELEASE;
                    rel_start = 1'b1;
                end
            end
            LOAD: begin
                if (ld_rst_ni) begin
                    state_nxt = RELEASE;
                    rel_start = 1'b1;
                end else if (ld_req_i) begin
                    capture = 1'b1;
                    if (in_window) begin
                        state_nxt = ISSUE;
                    end else begin
                        err_set    = 1'b1;
                        rvalid_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                err_set  = ld_req_i;
                pend_set = ld_rst_ni;
                if (mem_gnt_i) begin
                    account   = mem_we_o;
                    state_nxt = WAIT_RV;
                end
            end
            WAIT_RV: begin
                err_set  = ld_req_i;
                pend_set = ld_rst_ni;
                if (mem_rvalid_i) begin
                    rvalid_nxt = 1'b1;
                    pend_clr   = 1'b1;
                    if (pend_release || ld_rst_ni) begin
                        state_nxt = RELEASE;
                        rel_start = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            RELEASE: begin
                if (!ld_rst_ni) begin
                    state_nxt   = LOAD;
                    clear_stats = 1'b1;
                end else if (rel_cnt == REL_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!ld_rst_ni) begin
                    state_nxt   = LOAD;
                    clear_stats = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, pending-release flag and release delay counter.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state        <= IDLE;
            pend_release <= 1'b0;
            rel_cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (pend_clr) begin
                pend_release <= 1'b0;
            end else if (pend_set) begin
                pend_release <= 1'b1;
            end
            if (rel_start) begin
                rel_cnt <= '0;
            end else if (state == RELEASE) begin
                rel_cnt <= rel_cnt + 8'd1;
            end
        end
    end

    // Holding registers, completion pulse and load statistics.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
            ld_rvalid_o <= 1'b0;
            word_cnt_o  <= '0;
            checksum_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            ld_rvalid_o <= rvalid_nxt;
            if (capture) begin
                mem_we_o    <= ld_en_i;
                mem_addr_o  <= ld_addr_i;
                mem_wdata_o <= ld_wdata_i;
                mem_be_o    <= ld_be_i;
            end
            if (clear_stats) begin
                word_cnt_o <= '0;
                checksum_o <= '0;
                err_o      <= 1'b0;
            end else begin
                if (err_set) begin
                    err_o <= 1'b1;
                end
                if (account) begin
                    if (word_cnt_o != 16'hFFFF) begin
                        word_cnt_o <= word_cnt_o + 16'd1;
                    end
                    checksum_o <= checksum_o + (mem_wdata_o & be_to_mask(mem_be_o));
                end
            end
        end
    end

endmodule
